// File: rtl/instr_decode_if.sv
// ---------------------------------------------------------------------------
// instr_decode_if
//   Bundles the decode-stage signals: the fetched instruction and the
//   register-file write-back port coming in, and the decoded control,
//   operands, immediate and debug state going out.
//   master : drives instruction / instr_valid / wb_en / wb_addr / wb_data.
//   slave  : the decoder; drives rs_data, rt_data, imm_ext, dest_addr,
//            jump_target, alu_ctrl, reg_write, alu_src, mem_read, mem_write,
//            mem_to_reg, npc_sel, jump, illegal, instr_count.
// ---------------------------------------------------------------------------
interface instr_decode_if;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest_addr;
  logic [25:0] jump_target;
  logic [2:0]  alu_ctrl;
  logic        reg_write;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        npc_sel;
  logic        jump;
  logic        illegal;
  logic [31:0] instr_count;

  modport master (
    output instruction, instr_valid, wb_en, wb_addr, wb_data,
    input  rs_data, rt_data, imm_ext, dest_addr, jump_target, alu_ctrl,
           reg_write, alu_src, mem_read, mem_write, mem_to_reg,
           npc_sel, jump, illegal, instr_count
  );

  modport slave (
    input  instruction, instr_valid, wb_en, wb_addr, wb_data,
    output rs_data, rt_data, imm_ext, dest_addr, jump_target, alu_ctrl,
           reg_write, alu_src, mem_read, mem_write, mem_to_reg,
           npc_sel, jump, illegal, instr_count
  );
endinterface

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
//   Decode stage of the single-cycle MIPS-lite core. Decodes the fetched
//   instruction into datapath control, extends imm16, reads two operands
//   from the 32x32 register file and accepts write-back from the end of the
//   datapath. Also keeps a retired-instruction counter and a sticky
//   illegal-opcode flag for debug.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instr_decode_if.slave (instruction, write-back in; decode out)
//
// Parameters
//   SP_INIT : reset value of $29
//   GP_INIT : reset value of $28
//
// Build option
//   WB_BYPASS_EN : when defined, a write-back to a non-zero index that
//                  matches rs/rt is forwarded to rs_data/rt_data in the same
//                  cycle. When undefined, reads see the old register value.
// ---------------------------------------------------------------------------
module instr_decode #(
  parameter logic [31:0] SP_INIT = 32'h7fff_effc,
  parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_decode_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  logic [31:0] gpr_reg [32];
  logic [31:0] count_reg;
  logic        illegal_reg;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [15:0] imm16;

  assign opcode = bus.instruction[31:26];
  assign rs_idx = bus.instruction[25:21];
  assign rt_idx = bus.instruction[20:16];
  assign rd_idx = bus.instruction[15:11];
  assign imm16  = bus.instruction[15:0];
  assign funct  = bus.instruction[5:0];

  // -------------------------------------------------------------------------
  // Control decode. Raw decode first, then everything is forced to zero when
  // the slot is empty or the encoding is unsupported, so a bad or absent
  // instruction can never cause a write, a memory access or a redirect.
  // -------------------------------------------------------------------------
  logic       legal;
  logic       reg_write, alu_src, mem_read, mem_write, mem_to_reg, npc_sel, jump;
  logic [2:0] alu_ctrl;
  logic [4:0] dest_addr;

  always_comb begin
    legal      = 1'b1;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    npc_sel    = 1'b0;
    jump       = 1'b0;
    alu_ctrl   = ALU_ADD;
    dest_addr  = 5'd0;

    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        dest_addr = rd_idx;
        case (funct)
          FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUBU: alu_ctrl = ALU_SUB;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: legal    = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        dest_addr = rt_idx;
      end
      OP_ORI, OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = ALU_OR;
        dest_addr = rt_idx;
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        dest_addr  = rt_idx;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        dest_addr = rt_idx;
      end
      OP_BEQ: begin
        npc_sel   = 1'b1;
        alu_ctrl  = ALU_SUB;
        dest_addr = rt_idx;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!(bus.instr_valid && legal)) begin
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      npc_sel    = 1'b0;
      jump       = 1'b0;
      alu_ctrl   = ALU_ADD;
      dest_addr  = 5'd0;
    end
  end

  // Immediate extension depends only on the opcode field, not on validity.
  logic [31:0] imm_ext;
  always_comb begin
    case (opcode)
      OP_ORI:  imm_ext = {16'h0000, imm16};
      OP_LUI:  imm_ext = {imm16, 16'h0000};
      default: imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  end

  // -------------------------------------------------------------------------
  // Register file reads. gpr_reg[0] is held at zero, so $0 reads need no
  // special case; the bypass explicitly excludes index 0 for the same reason.
  // -------------------------------------------------------------------------
  logic rs_hit, rt_hit;
`ifdef WB_BYPASS_EN
  assign rs_hit = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == rs_idx);
  assign rt_hit = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == rt_idx);
`else
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
`endif

  assign bus.rs_data = rs_hit ? bus.wb_data : gpr_reg[rs_idx];
  assign bus.rt_data = rt_hit ? bus.wb_data : gpr_reg[rt_idx];

  // -------------------------------------------------------------------------
  // State: register file, retired counter, sticky illegal flag.
  // Reset wins over a write presented on the same edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        gpr_reg[i] <= (i == 28) ? GP_INIT :
                      (i == 29) ? SP_INIT : 32'h0;
      end
      count_reg   <= 32'h0;
      illegal_reg <= 1'b0;
    end else begin
      if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
        gpr_reg[bus.wb_addr] <= bus.wb_data;
      end
      if (bus.instr_valid) begin
        count_reg <= count_reg + 32'd1;  // wraps naturally
        if (!legal) begin
          illegal_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.imm_ext     = imm_ext;
  assign bus.dest_addr   = dest_addr;
  assign bus.jump_target = bus.instruction[25:0];
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.reg_write   = reg_write;
  assign bus.alu_src     = alu_src;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.npc_sel     = npc_sel;
  assign bus.jump        = jump;
  assign bus.illegal     = illegal_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_instr_decode.sv
// ---------------------------------------------------------------------------
// tb_instr_decode
//   Directed scenarios plus a randomized run against a table-driven model of
//   the decode rules, register file, counter and illegal flag. Inputs change
//   on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_instr_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  instr_decode_if bus();

  instr_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_gpr [32];
  logic [31:0] ref_count;
  logic        ref_illegal;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic bit ref_legal(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:   return (ins[5:0] == 6'h21) || (ins[5:0] == 6'h23) || (ins[5:0] == 6'h2a);
      6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Packed as {reg_write, alu_src, mem_read, mem_write, mem_to_reg, npc_sel, jump, alu_ctrl, dest}
  function automatic logic [14:0] ref_ctrl(input logic [31:0] ins, input logic v);
    logic [14:0] c;
    c = '0;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h21) c = {7'b1000000, 3'd0, ins[15:11]};
        if (ins[5:0] == 6'h23) c = {7'b1000000, 3'd1, ins[15:11]};
        if (ins[5:0] == 6'h2a) c = {7'b1000000, 3'd3, ins[15:11]};
      end
      6'h09: c = {7'b1100000, 3'd0, ins[20:16]};
      6'h0d: c = {7'b1100000, 3'd2, ins[20:16]};
      6'h0f: c = {7'b1100000, 3'd2, ins[20:16]};
      6'h23: c = {7'b1110100, 3'd0, ins[20:16]};
      6'h2b: c = {7'b0101000, 3'd0, ins[20:16]};
      6'h04: c = {7'b0000010, 3'd1, ins[20:16]};
      6'h02: c = {7'b0000001, 3'd0, 5'd0};
      default: c = '0;
    endcase
    return (v && ref_legal(ins)) ? c : 15'd0;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [15:0] imm;
    imm = ins[15:0];
    if (ins[31:26] == 6'h0d) return {16'h0, imm};
    if (ins[31:26] == 6'h0f) return {imm, 16'h0};
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
`endif
    return ref_gpr[idx];
  endfunction

  function automatic logic [14:0] got_ctrl();
    return {bus.reg_write, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
            bus.npc_sel, bus.jump, bus.alu_ctrl, bus.dest_addr};
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
    ref_gpr[28] = 32'h1000_8000;
    ref_gpr[29] = 32'h7fff_effc;
    ref_count   = 32'h0;
    ref_illegal = 1'b0;
  endtask

  // Wait for a rising edge and advance the model with the inputs seen there.
  task automatic clock_edge();
    @(posedge clk);
    if (!rst_n) begin
      ref_reset();
    end else begin
      if (bus.wb_en && bus.wb_addr != 5'd0) ref_gpr[bus.wb_addr] = bus.wb_data;
      if (bus.instr_valid) begin
        ref_count = ref_count + 32'd1;
        if (!ref_legal(bus.instruction)) ref_illegal = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_inputs(input logic [31:0] ins, input logic v, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.instruction = ins;
    bus.instr_valid = v;
    bus.wb_en       = we;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.instruction = mk_r(5'd29, 5'd28, 5'd0, 6'h21);
    bus.instr_valid = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
    #2 rst_n = 1'b0;
    clock_edge();
    clock_edge();
    set_inputs(mk_r(5'd29, 5'd28, 5'd0, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (bus.rs_data !== 32'h7fffeffc) begin errors++; $display("FAIL reset_sp got=%h exp=%h", bus.rs_data, 32'h7fffeffc); end
    checks++; if (bus.rt_data !== 32'h10008000) begin errors++; $display("FAIL reset_gp got=%h exp=%h", bus.rt_data, 32'h10008000); end
    checks++; if (bus.instr_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", bus.instr_count); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
    set_inputs(mk_r(5'd5, 5'd31, 5'd0, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    checks++; if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin errors++; $display("FAIL reset_other got=%h/%h exp=0/0", bus.rs_data, bus.rt_data); end
    clock_edge();
    $display("reset: sp/gp/count/illegal checked");
  endtask

  task automatic test_regfile_addu();
    set_inputs(32'h0, 1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    clock_edge();
    set_inputs(mk_r(5'd8, 5'd8, 5'd9, 6'h21), 1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (bus.rs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL addu_rs got=%h exp=deadbeef", bus.rs_data); end
    checks++; if (bus.rt_data !== 32'hDEADBEEF) begin errors++; $display("FAIL addu_rt got=%h exp=deadbeef", bus.rt_data); end
    checks++; if (bus.reg_write !== 1'b1 || bus.dest_addr !== 5'd9 || bus.alu_ctrl !== 3'd0 || bus.alu_src !== 1'b0)
      begin errors++; $display("FAIL addu_ctrl got rw=%b dest=%0d alu=%0d src=%b exp rw=1 dest=9 alu=0 src=0", bus.reg_write, bus.dest_addr, bus.alu_ctrl, bus.alu_src); end
    clock_edge();
    set_inputs(32'h0, 1'b0, 1'b1, 5'd0, 32'h1234);
    clock_edge();
    set_inputs(mk_r(5'd0, 5'd0, 5'd1, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL zero_reg got=%h exp=0", bus.rs_data); end
    clock_edge();
    $display("regfile: $8 write, addu $9,$8,$8, $0 write dropped");
  endtask

  task automatic test_imm();
    set_inputs(mk_i(6'h0d, 5'd1, 5'd2, 16'h8001), 1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (bus.imm_ext !== 32'h00008001) begin errors++; $display("FAIL imm_ori got=%h exp=00008001", bus.imm_ext); end
    clock_edge();
    set_inputs(mk_i(6'h09, 5'd1, 5'd2, 16'h8001), 1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (bus.imm_ext !== 32'hFFFF8001) begin errors++; $display("FAIL imm_addiu got=%h exp=ffff8001", bus.imm_ext); end
    clock_edge();
    set_inputs(mk_i(6'h0f, 5'd1, 5'd2, 16'h8001), 1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (bus.imm_ext !== 32'h80010000) begin errors++; $display("FAIL imm_lui got=%h exp=80010000", bus.imm_ext); end
    clock_edge();
    $display("imm: ori/addiu/lui extension checked");
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp;
    set_inputs(32'h0, 1'b0, 1'b1, 5'd5, 32'h1111_1111);
    clock_edge();
    set_inputs(mk_r(5'd5, 5'd0, 5'd0, 6'h21), 1'b0, 1'b1, 5'd5, 32'h2222_2222);
`ifdef WB_BYPASS_EN
    exp = 32'h2222_2222;
`else
    exp = 32'h1111_1111;
`endif
    checks++; if (bus.rs_data !== exp) begin errors++; $display("FAIL rdw_same_cycle got=%h exp=%h", bus.rs_data, exp); end
    clock_edge();
    set_inputs(mk_r(5'd5, 5'd0, 5'd0, 6'h21), 1'b0, 1'b1, 5'd0, 32'h3333_3333);
    checks++; if (bus.rs_data !== 32'h2222_2222) begin errors++; $display("FAIL rdw_next_cycle got=%h exp=22222222", bus.rs_data); end
    checks++; if (bus.rt_data !== 32'h0) begin errors++; $display("FAIL rdw_zero_idx got=%h exp=0", bus.rt_data); end
    clock_edge();
    $display("rdw: same-cycle read of $5 checked");
  endtask

  task automatic test_illegal();
    set_inputs(mk_i(6'h3f, 5'd3, 5'd4, 16'h0), 1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (got_ctrl() !== 15'd0 || bus.jump !== 1'b0) begin errors++; $display("FAIL illegal_ctrl got=%h exp=0", got_ctrl()); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_before_edge got=%b exp=0", bus.illegal); end
    clock_edge();
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_set got=%b exp=1", bus.illegal); end
    set_inputs(mk_r(5'd1, 5'd2, 5'd3, 6'h23), 1'b1, 1'b0, 5'd0, 32'h0);
    clock_edge();
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b exp=1", bus.illegal); end
    checks++; if (bus.instr_count !== ref_count) begin errors++; $display("FAIL illegal_count got=%h exp=%h", bus.instr_count, ref_count); end
    $display("illegal: opcode 3f flagged and sticky");
  endtask

  task automatic test_invalid();
    logic [31:0] held;
    held = ref_count;
    set_inputs(mk_i(6'h23, 5'd1, 5'd2, 16'h0004), 1'b0, 1'b0, 5'd0, 32'h0);
    checks++; if (got_ctrl() !== 15'd0) begin errors++; $display("FAIL invalid_ctrl got=%h exp=0", got_ctrl()); end
    clock_edge();
    checks++; if (bus.instr_count !== held) begin errors++; $display("FAIL invalid_count got=%h exp=%h", bus.instr_count, held); end
    $display("invalid: lw with instr_valid=0 has no effect");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    dut.count_reg = 32'hFFFF_FFFF;
    ref_count = 32'hFFFF_FFFF;
    bus.instruction = mk_i(6'h02, 5'd0, 5'd0, 16'h0);
    bus.instr_valid = 1'b1;
    bus.wb_en = 1'b0;
    #1;
    clock_edge();
    checks++; if (bus.instr_count !== 32'h0) begin errors++; $display("FAIL count_wrap got=%h exp=0", bus.instr_count); end
    $display("wrap: count ffffffff -> 0");
  endtask

  task automatic test_reset_override();
    set_inputs(32'h0, 1'b1, 1'b1, 5'd6, 32'hCAFE_F00D);
    rst_n = 1'b0;
    clock_edge();
    set_inputs(mk_r(5'd6, 5'd29, 5'd0, 6'h21), 1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    checks++; if (bus.rs_data !== 32'h0) begin errors++; $display("FAIL reset_blocks_write got=%h exp=0", bus.rs_data); end
    checks++; if (bus.illegal !== 1'b0 || bus.instr_count !== 32'h0) begin errors++; $display("FAIL reset_clears got ill=%b cnt=%h exp 0/0", bus.illegal, bus.instr_count); end
    clock_edge();
    $display("reset: write on reset edge dropped");
  endtask

  task automatic test_random(input int n);
    logic [5:0]  ops [9];
    logic [5:0]  fns [4];
    logic [31:0] ins;
    logic [5:0]  op;
    logic [4:0]  wa;
    int          errs_before;
    ops = '{6'h00, 6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f};
    fns = '{6'h21, 6'h23, 6'h2a, 6'h20};
    for (int it = 0; it < n; it++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 31) == 0) op = ops[8];
      ins = {op, 5'($urandom), 5'($urandom), 16'($urandom)};
      if (op == 6'h00) ins[5:0] = fns[$urandom_range(0, ($urandom_range(0, 15) == 0) ? 3 : 2)];
      wa = ($urandom_range(0, 2) == 0) ? ins[25:21] : 5'($urandom);
      set_inputs(ins, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, wa, $urandom);
      errs_before = errors;
      checks++; if (bus.rs_data !== ref_read(ins[25:21])) begin errors++; $display("FAIL rnd_rs it=%0d got=%h exp=%h", it, bus.rs_data, ref_read(ins[25:21])); end
      checks++; if (bus.rt_data !== ref_read(ins[20:16])) begin errors++; $display("FAIL rnd_rt it=%0d got=%h exp=%h", it, bus.rt_data, ref_read(ins[20:16])); end
      checks++; if (bus.imm_ext !== ref_imm(ins)) begin errors++; $display("FAIL rnd_imm it=%0d got=%h exp=%h", it, bus.imm_ext, ref_imm(ins)); end
      checks++; if (bus.jump_target !== ins[25:0]) begin errors++; $display("FAIL rnd_jt it=%0d got=%h exp=%h", it, bus.jump_target, ins[25:0]); end
      checks++; if (got_ctrl() !== ref_ctrl(ins, bus.instr_valid)) begin errors++; $display("FAIL rnd_ctrl it=%0d ins=%h got=%h exp=%h", it, ins, got_ctrl(), ref_ctrl(ins, bus.instr_valid)); end
      checks++; if (bus.illegal !== ref_illegal) begin errors++; $display("FAIL rnd_illegal it=%0d got=%b exp=%b", it, bus.illegal, ref_illegal); end
      checks++; if (bus.instr_count !== ref_count) begin errors++; $display("FAIL rnd_count it=%0d got=%h exp=%h", it, bus.instr_count, ref_count); end
      $display("rnd %0d: ins=%h v=%b wb=%b/%0d -> %s", it, ins, bus.instr_valid, bus.wb_en, wa,
               (errors == errs_before) ? "ok" : "bad");
      clock_edge();
    end
  endtask

  initial begin
    ref_reset();
    test_reset();
    test_regfile_addu();
    test_imm();
    test_read_during_write();
    test_illegal();
    test_invalid();
    test_wrap();
    test_reset_override();
    test_random(300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
